// File: rtl/sdram_arbiter_pkg.sv
// Shared types and default sizes for the SDRAM user-port arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 24;
  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned LEN_W_DEF        = 10;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    FIN   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_DRAW = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Arbiter sharing the SDRAM core user port between the display line fetcher
// (burst reads, fixed priority) and the draw engine (burst writes) with a
// starvation guard for draw. Bursts run to completion once granted.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned LEN_W        = LEN_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [LEN_W-1:0]  disp_len,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_done,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [LEN_W-1:0]  draw_len,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_wready,
  output logic              draw_gnt,
  output logic              draw_done,
  input  logic              core_init_done,
  output logic              core_req,
  output logic              core_we,
  output logic [ADDR_W-1:0] core_addr,
  output logic [LEN_W-1:0]  core_len,
  input  logic              core_ack,
  output logic [DATA_W-1:0] core_wdata,
  input  logic              core_wready,
  input  logic [DATA_W-1:0] core_rdata,
  input  logic              core_rvalid,
  input  logic              core_done,
  output logic              proto_err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BW       = LEN_W + 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  arb_state_t          state;
  arb_owner_t          owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic [BW-1:0]       beat_cnt;
  logic                zero_len;

  logic                sel_draw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic                owner_disp;
  logic                owner_draw;
  logic [BW-1:0]       beat_total;

  // Owner selection and data-path routing; routing is live only in XFER.
  always_comb begin
    sel_draw    = !(disp_req && !(draw_req && (starve_cnt == STARVE_MAX)));
    sel_addr    = sel_draw ? draw_addr : disp_addr;
    sel_len     = sel_draw ? draw_len : disp_len;
    owner_disp  = (state == XFER) && (owner == OWN_DISP);
    owner_draw  = (state == XFER) && (owner == OWN_DRAW);
    disp_rvalid = core_rvalid & owner_disp;
    disp_rdata  = owner_disp ? core_rdata : '0;
    draw_wready = core_wready & owner_draw;
    core_wdata  = owner_draw ? draw_wdata : '0;
    beat_total  = beat_cnt + BW'(disp_rvalid | draw_wready);
  end

  // Arbitration FSM with registered grant/done/command outputs.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_DISP;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      zero_len   <= 1'b0;
      core_req   <= 1'b0;
      core_we    <= 1'b0;
      core_addr  <= '0;
      core_len   <= '0;
      disp_gnt   <= 1'b0;
      draw_gnt   <= 1'b0;
      disp_done  <= 1'b0;
      draw_done  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      disp_gnt  <= 1'b0;
      draw_gnt  <= 1'b0;
      disp_done <= 1'b0;
      draw_done <= 1'b0;
      case (state)
        IDLE: begin
          if (core_init_done && (disp_req || draw_req)) begin
            owner     <= sel_draw ? OWN_DRAW : OWN_DISP;
            disp_gnt  <= !sel_draw;
            draw_gnt  <= sel_draw;
            core_addr <= sel_addr;
            core_len  <= sel_len;
            core_we   <= sel_draw;
            beat_cnt  <= '0;
            zero_len  <= (sel_len == '0);
            core_req  <= (sel_len != '0);
            state     <= (sel_len == '0) ? FIN : ISSUE;
            if (sel_draw || !draw_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + STARVE_ONE;
            end
          end
        end
        ISSUE: begin
          if (core_ack) begin
            core_req <= 1'b0;
            state    <= XFER;
          end
        end
        XFER: begin
          beat_cnt <= beat_total;
          if (core_done) begin
            disp_done <= (owner == OWN_DISP);
            draw_done <= (owner == OWN_DRAW);
            if (beat_total != {1'b0, core_len}) begin
              proto_err <= 1'b1;
            end
            state <= FIN;
          end
        end
        FIN: begin
          // A zero-length grant skips the core; its done pulse comes out here.
          if (zero_len) begin
            disp_done <= (owner == OWN_DISP);
            draw_done <= (owner == OWN_DRAW);
            zero_len  <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
